// File: rtl/seg7_scan_driver.sv
// Two-digit (NUM_DIGITS) seven-segment scan driver: double-buffered frame sink, multiplexed anode scan with blanking.
// Latency: accepted frame shown from the next frame boundary (worst case one frame period + 1 cycle); outputs registered 1 cycle after FSM state.
// Backpressure: s_ready = !pending; one frame buffered in the shadow register, s_ready returns the cycle after the boundary that consumes it.
//
// Ports:
//   clk, rstn       - clock, asynchronous active-low reset
//   s_valid/s_ready - frame handshake; s_data carries per-digit 7-bit codes (index 0 = LS digit, bit order gfedcba)
//   an              - active-low digit enables, at most one low at any time
//   seg             - segment lines, inverted when SEG_ACTIVE_LOW = 1
//   frame_tick      - one-cycle pulse following each frame boundary
// Optional build macro: SEG7_DECODE_EN - decode binary digit values into segment patterns when loading the display.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 2,
    parameter int REFRESH_CYCLES = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [NUM_DIGITS-1:0][6:0]   s_data,
    output logic [NUM_DIGITS-1:0]        an,
    output logic [6:0]                   seg,
    output logic                         frame_tick
);

    localparam int MAXC = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int DW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);
    // XOR mask: turns a lit-high pattern into the pin polarity; also the "all off" value.
    localparam logic [6:0]    SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;

    typedef enum logic {
        ST_SCAN  = 1'b0,
        ST_BLANK = 1'b1
    } state_e;

    state_e                       state_q, state_d;
    logic [DW-1:0]                digit_q, digit_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][6:0]   shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][6:0]   disp_q, disp_d;
    logic                         pending_q, pending_d;
    logic [NUM_DIGITS-1:0]        an_q, an_d;
    logic [6:0]                   seg_q, seg_d;
    logic                         tick_q, tick_d;
    logic                         boundary;
    logic                         xfer;

`ifdef SEG7_DECODE_EN
    // Binary digit value to gfedcba pattern (lit = 1); anything outside 0..9 shows a dash.
    function automatic logic [6:0] decode_digit(input logic [6:0] v);
        logic [6:0] r;
        r = 7'b1000000;
        if (v[6:4] == 3'b000) begin
            case (v[3:0])
                4'd0:    r = 7'b0111111;
                4'd1:    r = 7'b0000110;
                4'd2:    r = 7'b1011011;
                4'd3:    r = 7'b1001111;
                4'd4:    r = 7'b1100110;
                4'd5:    r = 7'b1101101;
                4'd6:    r = 7'b1111101;
                4'd7:    r = 7'b0000111;
                4'd8:    r = 7'b1111111;
                4'd9:    r = 7'b1101111;
                default: r = 7'b1000000;
            endcase
        end
        return r;
    endfunction

    function automatic logic [NUM_DIGITS-1:0][6:0] load_frame(input logic [NUM_DIGITS-1:0][6:0] f);
        logic [NUM_DIGITS-1:0][6:0] r;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[i] = decode_digit(f[i]);
        end
        return r;
    endfunction
`else
    // Raw build: fields are already segment patterns.
    function automatic logic [NUM_DIGITS-1:0][6:0] load_frame(input logic [NUM_DIGITS-1:0][6:0] f);
        return f;
    endfunction
`endif

    // Shadow is full exactly while pending; no separate ready flop needed.
    assign s_ready    = ~pending_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = tick_q;

    assign xfer     = s_valid & ~pending_q;
    // Last cycle of the blanking gap after the final digit.
    assign boundary = (state_q == ST_BLANK) && (cnt_q == BLK_LAST) && (digit_q == DIG_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_SCAN;
            digit_q   <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            an_q      <= '1;
            seg_q     <= SEG_OFF;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            digit_q   <= digit_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        digit_d   = digit_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        an_d      = '1;
        seg_d     = SEG_OFF;
        tick_d    = boundary;

        // Scan sequencing; an/seg reflect the current state one cycle later.
        case (state_q)
            ST_SCAN: begin
                an_d[digit_q] = 1'b0;
                seg_d         = disp_q[digit_q] ^ SEG_OFF;
                if (cnt_q == REF_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_BLANK: begin
                if (cnt_q == BLK_LAST) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_SCAN;
                cnt_d   = '0;
                digit_d = '0;
            end
        endcase

        // A handshake and a consuming boundary never coincide: ready is low while pending.
        if (xfer) begin
            shadow_d  = s_data;
            pending_d = 1'b1;
        end
        if (boundary && pending_q) begin
            disp_d    = load_frame(shadow_q);
            pending_d = 1'b0;
        end
    end

endmodule
